pipe_chain: RTL and testbench

Parametrised register chain that runs the same input through two lanes side by side. The staged lane is a true pipeline with one register per stage. The collapsed lane loads every stage with the input on the same edge, which is the behaviour of a chain where each stage copies the previous one within one update. Successor to the fixed 3-stage, 1-bit x/y/z vs xb/yb/zb demonstrator, generalised in width and depth, and adding per-stage valid tracking, stall, flush, occupancy and a lane-compare flag. Sits in the blocking vs non-blocking design examples as the reusable DUT for the shared bench.

---
 rtl/pipe_chain_pkg.sv | 13 +
 rtl/pipe_stage.sv | 30 +++
 rtl/pipe_chain.sv | 108 ++++++++++
 tb/tb_pipe_chain.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pipe_chain_pkg.sv
// Shared helpers for the dual-lane register chain.
// Occupancy width and packed stage slicing.
package pipe_chain_pkg;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int slice_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One data register plus valid bit.
// Flush behaves like reset but is sampled on the clock.
module pipe_stage #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= RESET_VAL;
      q_vld <= 1'b0;
    end else if (flush) begin
      q     <= RESET_VAL;
      q_vld <= 1'b0;
    end else if (en) begin
      q     <= d;
      q_vld <= d_vld;
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// Staged and collapsed register lanes fed from the same input,
// with per-stage valids, occupancy and a last-stage compare.
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_vld,
  output logic [DEPTH*WIDTH-1:0]    tap,
  output logic [DEPTH-1:0]          tap_vld,
  output logic [DEPTH*WIDTH-1:0]    tapb,
  output logic [DEPTH-1:0]          tapb_vld,
  output logic [WIDTH-1:0]          dout,
  output logic [occ_w(DEPTH)-1:0]   occ,
  output logic                      lanes_eq
);

  localparam int OW = occ_w(DEPTH);
  localparam int LAST = slice_lo(DEPTH - 1, WIDTH);

  logic [DEPTH-1:0] nxt_vld;
  logic [OW-1:0]    cnt;
  logic [WIDTH-1:0] last_s;
  logic [WIDTH-1:0] last_b;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    localparam int LO = slice_lo(k, WIDTH);
    logic [WIDTH-1:0] sd;
    logic             sv;

    if (k == 0) begin : g_head
      assign sd = din;
      assign sv = din_vld;
    end else begin : g_body
      assign sd = tap[LO-WIDTH +: WIDTH];
      assign sv = tap_vld[k-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_s (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .flush (flush),
      .d     (sd),
      .d_vld (sv),
      .q     (tap[LO +: WIDTH]),
      .q_vld (tap_vld[k])
    );

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_b (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .flush (flush),
      .d     (din),
      .d_vld (din_vld),
      .q     (tapb[LO +: WIDTH]),
      .q_vld (tapb_vld[k])
    );
  end

  // Predict the staged valids so occ lands on the same edge
  always_comb begin
    nxt_vld = tap_vld;
    if (flush) begin
      nxt_vld = '0;
    end else if (en) begin
      nxt_vld[0] = din_vld;
      for (int k = 1; k < DEPTH; k++) begin
        nxt_vld[k] = tap_vld[k-1];
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + OW'(nxt_vld[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ <= '0;
    else     occ <= cnt;
  end

  assign last_s = tap[LAST +: WIDTH];
  assign last_b = tapb[LAST +: WIDTH];
  assign dout   = last_s;

  assign lanes_eq =
    (tap_vld[DEPTH-1] && tapb_vld[DEPTH-1] && (last_s == last_b)) ||
    (!tap_vld[DEPTH-1] && !tapb_vld[DEPTH-1]);

endmodule

// File: tb/tb_pipe_chain.sv
// Directed vector bench for pipe_chain at WIDTH=4, DEPTH=3.
// Table rows plus hand sequences for reset corners.
module tb_pipe_chain;

  logic        clk;
  logic        clk_run;
  logic        rst;
  logic        en;
  logic        flush;
  logic [3:0]  din;
  logic        din_vld;
  logic [11:0] tap;
  logic [2:0]  tap_vld;
  logic [11:0] tapb;
  logic [2:0]  tapb_vld;
  logic [3:0]  dout;
  logic [1:0]  occ;
  logic        lanes_eq;

  int tests = 0;
  int fails = 0;

  pipe_chain #(
    .WIDTH     (4),
    .DEPTH     (3),
    .RESET_VAL (4'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .din      (din),
    .din_vld  (din_vld),
    .tap      (tap),
    .tap_vld  (tap_vld),
    .tapb     (tapb),
    .tapb_vld (tapb_vld),
    .dout     (dout),
    .occ      (occ),
    .lanes_eq (lanes_eq)
  );

  always #5 if (clk_run) clk = ~clk;

  typedef struct {
    logic        en;
    logic        flush;
    logic [3:0]  din;
    logic        dv;
    logic [11:0] tap;
    logic [2:0]  tv;
    logic [11:0] tapb;
    logic [2:0]  bv;
    logic [1:0]  occ;
    logic        eq;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(
    input logic e, input logic f, input logic [3:0] d, input logic v,
    input logic [3:0] s2, input logic [3:0] s1, input logic [3:0] s0,
    input logic [2:0] tv, input logic [3:0] b, input logic [2:0] bv,
    input logic [1:0] o, input logic q);
    vec_t r;
    r.en = e; r.flush = f; r.din = d; r.dv = v;
    r.tap = {s2, s1, s0}; r.tv = tv;
    r.tapb = {b, b, b}; r.bv = bv;
    r.occ = o; r.eq = q;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [11:0] et,
                         input logic [2:0] etv, input logic [11:0] eb,
                         input logic [2:0] ebv, input logic [1:0] eo,
                         input logic eq);
    chk({tag, ".tap"}, 16'(tap), 16'(et));
    chk({tag, ".tap_vld"}, 16'(tap_vld), 16'(etv));
    chk({tag, ".tapb"}, 16'(tapb), 16'(eb));
    chk({tag, ".tapb_vld"}, 16'(tapb_vld), 16'(ebv));
    chk({tag, ".dout"}, 16'(dout), 16'(et[11:8]));
    chk({tag, ".occ"}, 16'(occ), 16'(eo));
    chk({tag, ".lanes_eq"}, 16'(lanes_eq), 16'(eq));
  endtask

  task automatic apply(input int i);
    @(negedge clk);
    en      = vt[i].en;
    flush   = vt[i].flush;
    din     = vt[i].din;
    din_vld = vt[i].dv;
    @(posedge clk);
    #1;
    chk_all($sformatf("row%0d", i), vt[i].tap, vt[i].tv,
            vt[i].tapb, vt[i].bv, vt[i].occ, vt[i].eq);
  endtask

  initial begin
    // single token A
    vt[0]  = mk(1, 0, 4'hA, 1, 4'h0, 4'h0, 4'hA, 3'b001, 4'hA, 3'b111, 1, 0);
    vt[1]  = mk(1, 0, 4'h0, 0, 4'h0, 4'hA, 4'h0, 3'b010, 4'h0, 3'b000, 1, 1);
    vt[2]  = mk(1, 0, 4'h0, 0, 4'hA, 4'h0, 4'h0, 3'b100, 4'h0, 3'b000, 1, 0);
    vt[3]  = mk(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 0, 1);
    // stream 1..4
    vt[4]  = mk(1, 0, 4'h1, 1, 4'h0, 4'h0, 4'h1, 3'b001, 4'h1, 3'b111, 1, 0);
    vt[5]  = mk(1, 0, 4'h2, 1, 4'h0, 4'h1, 4'h2, 3'b011, 4'h2, 3'b111, 2, 0);
    vt[6]  = mk(1, 0, 4'h3, 1, 4'h1, 4'h2, 4'h3, 3'b111, 4'h3, 3'b111, 3, 0);
    vt[7]  = mk(1, 0, 4'h4, 1, 4'h2, 4'h3, 4'h4, 3'b111, 4'h4, 3'b111, 3, 0);
    // stall, then resume
    vt[8]  = mk(0, 0, 4'h7, 1, 4'h2, 4'h3, 4'h4, 3'b111, 4'h4, 3'b111, 3, 0);
    vt[9]  = mk(0, 0, 4'h8, 0, 4'h2, 4'h3, 4'h4, 3'b111, 4'h4, 3'b111, 3, 0);
    vt[10] = mk(1, 0, 4'h5, 1, 4'h3, 4'h4, 4'h5, 3'b111, 4'h5, 3'b111, 3, 0);
    vt[11] = mk(1, 0, 4'h5, 1, 4'h4, 4'h5, 4'h5, 3'b111, 4'h5, 3'b111, 3, 0);
    vt[12] = mk(1, 0, 4'h5, 1, 4'h5, 4'h5, 4'h5, 3'b111, 4'h5, 3'b111, 3, 1);
    // flush beats en with F valid
    vt[13] = mk(1, 1, 4'hF, 1, 4'h0, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 0, 1);
    vt[14] = mk(0, 0, 4'hF, 1, 4'h0, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 0, 1);
    // partial stream before async reset
    vt[15] = mk(1, 0, 4'h6, 1, 4'h0, 4'h0, 4'h6, 3'b001, 4'h6, 3'b111, 1, 0);
    vt[16] = mk(1, 0, 4'h7, 1, 4'h0, 4'h6, 4'h7, 3'b011, 4'h7, 3'b111, 2, 0);

    clk = 0; clk_run = 0;
    rst = 1; en = 0; flush = 0; din = 4'h9; din_vld = 1;
    #3;
    chk_all("reset_idle", 12'h0, 3'b000, 12'h0, 3'b000, 0, 1);
    rst = 0;
    #3;
    chk_all("release_idle", 12'h0, 3'b000, 12'h0, 3'b000, 0, 1);
    en = 0;
    clk_run = 1;
    @(posedge clk);
    #1;
    chk_all("hold_edge", 12'h0, 3'b000, 12'h0, 3'b000, 0, 1);

    for (int i = 0; i < 17; i++) apply(i);

    // async reset between edges
    #2;
    rst = 1;
    #1;
    chk_all("async_rst", 12'h0, 3'b000, 12'h0, 3'b000, 0, 1);
    @(negedge clk);
    en = 1; din = 4'h9; din_vld = 1;
    @(posedge clk);
    #1;
    chk_all("rst_held", 12'h0, 3'b000, 12'h0, 3'b000, 0, 1);
    @(negedge clk);
    rst = 0; en = 0;
    @(posedge clk);
    #1;
    chk_all("rst_release", 12'h0, 3'b000, 12'h0, 3'b000, 0, 1);

    for (int i = 4; i < 8; i++) apply(i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
